// File: rtl/psg_pkg.sv
// Shared definitions for the PSG bus scheduler: FSM state encoding,
// BDIR/BC bus codes and requester indices.
package psg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WR,
        ST_RD,
        ST_GAP
    } psg_state_t;

    localparam logic [1:0] PSG_INACT = 2'b00;
    localparam logic [1:0] PSG_READ  = 2'b01;
    localparam logic [1:0] PSG_WRITE = 2'b10;
    localparam logic [1:0] PSG_ADDR  = 2'b11;

    localparam int REQ_CPU = 0;
    localparam int REQ_SEQ = 1;

    // {BDIR, BC} driven while the FSM sits in a given state
    function automatic logic [1:0] psg_bus_code(input psg_state_t st);
        case (st)
            ST_ADDR: psg_bus_code = PSG_ADDR;
            ST_WR:   psg_bus_code = PSG_WRITE;
            ST_RD:   psg_bus_code = PSG_READ;
            default: psg_bus_code = PSG_INACT;
        endcase
    endfunction

endpackage

// File: rtl/psg_rr_arb.sv
// Two-input round-robin arbiter; a tie goes to whichever requester was not
// granted last, and the history bit only moves when a grant is taken.
module psg_rr_arb
    import psg_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    // r_last = 1 means the sequencer won most recently, so the CPU takes the first tie
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last <= 1'b1;
        end else if (i_en && (|o_gnt)) begin
            r_last <= o_gnt[REQ_SEQ];
        end
    end

endmodule

// File: rtl/psg_bus_sched.sv
// Bus sequencer in front of the YM2149: arbitrates CPU and sequencer requests
// and turns each grant into BDIR/BC address-latch and data cycles.
module psg_bus_sched
    import psg_pkg::*;
#(
    parameter int GAP       = 2,
    parameter int SKIP_ADDR = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       cpu_ack,
    output logic [7:0] cpu_dout,
    input  logic       seq_req,
    input  logic [3:0] seq_addr,
    input  logic [7:0] seq_din,
    output logic       seq_ack,
    output logic       psg_bdir,
    output logic       psg_bc,
    output logic [7:0] psg_di,
    input  logic [7:0] psg_do,
    output logic       busy
);

    psg_state_t r_state;
    psg_state_t w_next;

    logic [3:0] r_addr;
    logic [7:0] r_data;
    logic       r_we;
    logic       r_owner_seq;
    logic [3:0] r_lat_addr;
    logic       r_lat_valid;
    logic [3:0] r_gap_cnt;
    logic       r_cpu_ack;
    logic       r_seq_ack;
    logic [7:0] r_cpu_dout;
    logic       r_bdir;
    logic       r_bc;
    logic [7:0] r_di;
    logic       r_busy;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_arb_en;
    logic       w_grant;
    logic       w_gnt_seq;
    logic       w_gnt_we;
    logic [3:0] w_gnt_addr;
    logic [7:0] w_gnt_data;
    logic       w_elide;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic [1:0] w_code;
    logic       w_enter_gap;

    assign w_req    = {seq_req, cpu_req};
    assign w_arb_en = (r_state == ST_IDLE);

    psg_rr_arb u_arb (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_en    (w_arb_en),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    // Granted request, and the address/data the next bus cycle will carry
    always_comb begin
        w_grant    = w_arb_en && (|w_gnt);
        w_gnt_seq  = w_gnt[REQ_SEQ];
        w_gnt_addr = w_gnt_seq ? seq_addr : cpu_addr;
        w_gnt_data = w_gnt_seq ? seq_din  : cpu_din;
        w_gnt_we   = w_gnt_seq | cpu_we;
        w_elide    = (SKIP_ADDR != 0) && r_lat_valid && (r_lat_addr == w_gnt_addr);
        w_addr     = w_grant ? w_gnt_addr : r_addr;
        w_data     = w_grant ? w_gnt_data : r_data;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    if (w_elide) begin
                        w_next = w_gnt_we ? ST_WR : ST_RD;
                    end else begin
                        w_next = ST_ADDR;
                    end
                end
            end
            ST_ADDR: w_next = r_we ? ST_WR : ST_RD;
            ST_WR:   w_next = ST_GAP;
            ST_RD:   w_next = ST_GAP;
            ST_GAP: begin
                if (r_gap_cnt <= 4'd1) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_code      = psg_bus_code(w_next);
    assign w_enter_gap = (w_next == ST_GAP) && (r_state != ST_GAP);

    // Bus pins, acks and busy are registered from the next state so they change cleanly on edges
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_addr      <= 4'h0;
            r_data      <= 8'h00;
            r_we        <= 1'b0;
            r_owner_seq <= 1'b0;
            r_lat_addr  <= 4'h0;
            r_lat_valid <= 1'b0;
            r_gap_cnt   <= 4'h0;
            r_cpu_ack   <= 1'b0;
            r_seq_ack   <= 1'b0;
            r_cpu_dout  <= 8'h00;
            r_bdir      <= 1'b0;
            r_bc        <= 1'b0;
            r_di        <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_addr      <= w_gnt_addr;
                r_data      <= w_gnt_data;
                r_we        <= w_gnt_we;
                r_owner_seq <= w_gnt_seq;
            end
            if (r_state == ST_ADDR) begin
                r_lat_addr  <= r_addr;
                r_lat_valid <= 1'b1;
            end
            if (w_enter_gap) begin
                r_gap_cnt <= 4'(GAP);
            end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
            if (r_state == ST_RD) begin
                r_cpu_dout <= psg_do;
            end
            r_cpu_ack <= w_enter_gap && !r_owner_seq;
            r_seq_ack <= w_enter_gap && r_owner_seq;
            r_bdir    <= w_code[1];
            r_bc      <= w_code[0];
            case (w_next)
                ST_ADDR: r_di <= {4'h0, w_addr};
                ST_WR:   r_di <= w_data;
                default: r_di <= 8'h00;
            endcase
            r_busy <= (w_next != ST_IDLE);
        end
    end

    assign cpu_ack  = r_cpu_ack;
    assign seq_ack  = r_seq_ack;
    assign cpu_dout = r_cpu_dout;
    assign psg_bdir = r_bdir;
    assign psg_bc   = r_bc;
    assign psg_di   = r_di;
    assign busy     = r_busy;

endmodule
